alu2_reservation_station: RTL and testbench

Four-entry reservation station that sits directly upstream of the ALU2 execute port. It accepts dispatched ALU2 micro-ops whose operands may still be pending, captures missing operands from two result-broadcast buses by commit-tag match, and issues one ready micro-op per cycle into the ALU2 execute stage through a registered issue interface. It honours the execute-side lock and the pipeline-wide flush (`iFREE_EX`).

---
 rtl/alu2_reservation_station.sv | 247 ++++++++++++++++++++++++
 tb/tb_alu2_reservation_station.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu2_reservation_station.sv
// Four-entry ALU2 reservation station: captures pending operands from two
// result buses and issues the lowest-index ready micro-op into a register.
// Ports:
//   iCLOCK, inRESET (async, active-low), iFREE_EX (sync flush)
//   iDISP_* dispatch bundle in, oDISP_LOCK out (station full)
//   iWAKE0_*, iWAKE1_* result broadcasts (WAKE0 wins on a double match)
//   oEX_ALU2_* registered issue bundle, iEX_ALU2_LOCK freezes it
module alu2_reservation_station #(
   parameter int ENTRIES = 4
) (
   input  logic        iCLOCK,
   input  logic        inRESET,
   input  logic        iFREE_EX,
   input  logic        iDISP_VALID,
   input  logic        iDISP_WRITEBACK,
   input  logic [5:0]  iDISP_COMMIT_TAG,
   input  logic [4:0]  iDISP_CMD,
   input  logic [3:0]  iDISP_AFE,
   input  logic        iDISP_SYS_REG,
   input  logic        iDISP_LOGIC,
   input  logic        iDISP_SHIFT,
   input  logic        iDISP_ADDER,
   input  logic        iDISP_SRC0_VALID,
   input  logic [31:0] iDISP_SRC0,
   input  logic        iDISP_SRC1_VALID,
   input  logic [31:0] iDISP_SRC1,
   input  logic        iDISP_DESTINATION_SYSREG,
   input  logic [5:0]  iDISP_DESTINATION_REGNAME,
   input  logic        iDISP_FLAGS_WRITEBACK,
   input  logic [3:0]  iDISP_FLAGS_REGNAME,
   output logic        oDISP_LOCK,
   input  logic        iWAKE0_VALID,
   input  logic [5:0]  iWAKE0_TAG,
   input  logic [31:0] iWAKE0_DATA,
   input  logic        iWAKE1_VALID,
   input  logic [5:0]  iWAKE1_TAG,
   input  logic [31:0] iWAKE1_DATA,
   output logic        oEX_ALU2_VALID,
   output logic        oEX_ALU2_WRITEBACK,
   output logic [5:0]  oEX_ALU2_COMMIT_TAG,
   output logic [4:0]  oEX_ALU2_CMD,
   output logic [3:0]  oEX_ALU2_AFE,
   output logic        oEX_ALU2_SYS_REG,
   output logic        oEX_ALU2_LOGIC,
   output logic        oEX_ALU2_SHIFT,
   output logic        oEX_ALU2_ADDER,
   output logic [31:0] oEX_ALU2_SOURCE0,
   output logic [31:0] oEX_ALU2_SOURCE1,
   output logic        oEX_ALU2_DESTINATION_SYSREG,
   output logic [5:0]  oEX_ALU2_DESTINATION_REGNAME,
   output logic        oEX_ALU2_FLAGS_WRITEBACK,
   output logic [3:0]  oEX_ALU2_FLAGS_REGNAME,
   input  logic        iEX_ALU2_LOCK
);

   typedef struct packed {
      logic        wb;
      logic [5:0]  tag;
      logic [4:0]  cmd;
      logic [3:0]  afe;
      logic        sys_reg;
      logic        logic_u;
      logic        shift;
      logic        adder;
      logic [31:0] src0;
      logic [31:0] src1;
      logic        dst_sys;
      logic [5:0]  dst_reg;
      logic        fl_wb;
      logic [3:0]  fl_reg;
   } uop_t;

   logic [ENTRIES-1:0] valid_q, valid_d;
   logic [ENTRIES-1:0] rdy0_q, rdy0_d;
   logic [ENTRIES-1:0] rdy1_q, rdy1_d;
   uop_t               uop_q [ENTRIES];
   uop_t               uop_d [ENTRIES];

   logic iss_vld_q, iss_vld_d;
   uop_t iss_q, iss_d;

   logic [1:0]  free_idx;
   logic [1:0]  sel_idx;
   logic        any_rdy;
   logic        disp_acc;
   logic        issue;
   logic        d_rdy0, d_rdy1;
   logic [31:0] d_src0, d_src1;
   uop_t        disp_uop;

   assign oDISP_LOCK = &valid_q;
   assign disp_acc   = iDISP_VALID & ~oDISP_LOCK & ~iFREE_EX;
   assign issue      = any_rdy & ~iEX_ALU2_LOCK & ~iFREE_EX;

   // Lowest-index free slot and lowest-index ready slot.
   always_comb begin
      free_idx = '0;
      sel_idx  = '0;
      any_rdy  = 1'b0;
      for (int i = ENTRIES - 1; i >= 0; i--) begin
         if (!valid_q[i]) begin
            free_idx = 2'(i);
         end
         if (valid_q[i] && rdy0_q[i] && rdy1_q[i]) begin
            sel_idx = 2'(i);
            any_rdy = 1'b1;
         end
      end
   end

   // A pending dispatch operand can be satisfied by this cycle's broadcast.
   always_comb begin
      d_rdy0 = iDISP_SRC0_VALID;
      d_src0 = iDISP_SRC0;
      if (!iDISP_SRC0_VALID) begin
         if (iWAKE0_VALID && iWAKE0_TAG == iDISP_SRC0[5:0]) begin
            d_rdy0 = 1'b1;
            d_src0 = iWAKE0_DATA;
         end else if (iWAKE1_VALID && iWAKE1_TAG == iDISP_SRC0[5:0]) begin
            d_rdy0 = 1'b1;
            d_src0 = iWAKE1_DATA;
         end
      end
      d_rdy1 = iDISP_SRC1_VALID;
      d_src1 = iDISP_SRC1;
      if (!iDISP_SRC1_VALID) begin
         if (iWAKE0_VALID && iWAKE0_TAG == iDISP_SRC1[5:0]) begin
            d_rdy1 = 1'b1;
            d_src1 = iWAKE0_DATA;
         end else if (iWAKE1_VALID && iWAKE1_TAG == iDISP_SRC1[5:0]) begin
            d_rdy1 = 1'b1;
            d_src1 = iWAKE1_DATA;
         end
      end
   end

   always_comb begin
      disp_uop.wb      = iDISP_WRITEBACK;
      disp_uop.tag     = iDISP_COMMIT_TAG;
      disp_uop.cmd     = iDISP_CMD;
      disp_uop.afe     = iDISP_AFE;
      disp_uop.sys_reg = iDISP_SYS_REG;
      disp_uop.logic_u = iDISP_LOGIC;
      disp_uop.shift   = iDISP_SHIFT;
      disp_uop.adder   = iDISP_ADDER;
      disp_uop.src0    = d_src0;
      disp_uop.src1    = d_src1;
      disp_uop.dst_sys = iDISP_DESTINATION_SYSREG;
      disp_uop.dst_reg = iDISP_DESTINATION_REGNAME;
      disp_uop.fl_wb   = iDISP_FLAGS_WRITEBACK;
      disp_uop.fl_reg  = iDISP_FLAGS_REGNAME;
   end

   // Entry next state: wakeup, then issue release, then dispatch fill.
   // The dispatch slot is free, so it never collides with the issued slot.
   always_comb begin
      valid_d = valid_q;
      rdy0_d  = rdy0_q;
      rdy1_d  = rdy1_q;
      uop_d   = uop_q;
      for (int i = 0; i < ENTRIES; i++) begin
         if (valid_q[i] && !rdy0_q[i]) begin
            if (iWAKE0_VALID && iWAKE0_TAG == uop_q[i].src0[5:0]) begin
               rdy0_d[i]      = 1'b1;
               uop_d[i].src0 = iWAKE0_DATA;
            end else if (iWAKE1_VALID && iWAKE1_TAG == uop_q[i].src0[5:0]) begin
               rdy0_d[i]      = 1'b1;
               uop_d[i].src0 = iWAKE1_DATA;
            end
         end
         if (valid_q[i] && !rdy1_q[i]) begin
            if (iWAKE0_VALID && iWAKE0_TAG == uop_q[i].src1[5:0]) begin
               rdy1_d[i]      = 1'b1;
               uop_d[i].src1 = iWAKE0_DATA;
            end else if (iWAKE1_VALID && iWAKE1_TAG == uop_q[i].src1[5:0]) begin
               rdy1_d[i]      = 1'b1;
               uop_d[i].src1 = iWAKE1_DATA;
            end
         end
         if (issue && sel_idx == 2'(i)) begin
            valid_d[i] = 1'b0;
         end
         if (disp_acc && free_idx == 2'(i)) begin
            valid_d[i] = 1'b1;
            rdy0_d[i]  = d_rdy0;
            rdy1_d[i]  = d_rdy1;
            uop_d[i]   = disp_uop;
         end
      end
      if (iFREE_EX) begin
         valid_d = '0;
      end
   end

   // Issue register: frozen under the execute lock, cleared by flush.
   always_comb begin
      iss_vld_d = iss_vld_q;
      iss_d     = iss_q;
      if (iFREE_EX) begin
         iss_vld_d = 1'b0;
      end else if (!iEX_ALU2_LOCK) begin
         iss_vld_d = issue;
         if (issue) begin
            iss_d = uop_q[sel_idx];
         end
      end
   end

   always_ff @(posedge iCLOCK or negedge inRESET) begin
      if (!inRESET) begin
         valid_q   <= '0;
         rdy0_q    <= '0;
         rdy1_q    <= '0;
         iss_vld_q <= 1'b0;
         iss_q     <= '0;
         for (int i = 0; i < ENTRIES; i++) begin
            uop_q[i] <= '0;
         end
      end else begin
         valid_q   <= valid_d;
         rdy0_q    <= rdy0_d;
         rdy1_q    <= rdy1_d;
         iss_vld_q <= iss_vld_d;
         iss_q     <= iss_d;
         for (int i = 0; i < ENTRIES; i++) begin
            uop_q[i] <= uop_d[i];
         end
      end
   end

   assign oEX_ALU2_VALID               = iss_vld_q;
   assign oEX_ALU2_WRITEBACK           = iss_q.wb;
   assign oEX_ALU2_COMMIT_TAG          = iss_q.tag;
   assign oEX_ALU2_CMD                 = iss_q.cmd;
   assign oEX_ALU2_AFE                 = iss_q.afe;
   assign oEX_ALU2_SYS_REG             = iss_q.sys_reg;
   assign oEX_ALU2_LOGIC               = iss_q.logic_u;
   assign oEX_ALU2_SHIFT               = iss_q.shift;
   assign oEX_ALU2_ADDER               = iss_q.adder;
   assign oEX_ALU2_SOURCE0             = iss_q.src0;
   assign oEX_ALU2_SOURCE1             = iss_q.src1;
   assign oEX_ALU2_DESTINATION_SYSREG  = iss_q.dst_sys;
   assign oEX_ALU2_DESTINATION_REGNAME = iss_q.dst_reg;
   assign oEX_ALU2_FLAGS_WRITEBACK     = iss_q.fl_wb;
   assign oEX_ALU2_FLAGS_REGNAME       = iss_q.fl_reg;

endmodule

// File: tb/tb_alu2_reservation_station.sv
// Directed bench for alu2_reservation_station: dispatch, wakeup, fill,
// execute lock, flush and asynchronous reset, each against fixed values.
module tb_alu2_reservation_station;

   logic        iCLOCK = 1'b0;
   logic        inRESET;
   logic        iFREE_EX;
   logic        iDISP_VALID;
   logic        iDISP_WRITEBACK;
   logic [5:0]  iDISP_COMMIT_TAG;
   logic [4:0]  iDISP_CMD;
   logic [3:0]  iDISP_AFE;
   logic        iDISP_SYS_REG;
   logic        iDISP_LOGIC;
   logic        iDISP_SHIFT;
   logic        iDISP_ADDER;
   logic        iDISP_SRC0_VALID;
   logic [31:0] iDISP_SRC0;
   logic        iDISP_SRC1_VALID;
   logic [31:0] iDISP_SRC1;
   logic        iDISP_DESTINATION_SYSREG;
   logic [5:0]  iDISP_DESTINATION_REGNAME;
   logic        iDISP_FLAGS_WRITEBACK;
   logic [3:0]  iDISP_FLAGS_REGNAME;
   logic        oDISP_LOCK;
   logic        iWAKE0_VALID;
   logic [5:0]  iWAKE0_TAG;
   logic [31:0] iWAKE0_DATA;
   logic        iWAKE1_VALID;
   logic [5:0]  iWAKE1_TAG;
   logic [31:0] iWAKE1_DATA;
   logic        oEX_ALU2_VALID;
   logic        oEX_ALU2_WRITEBACK;
   logic [5:0]  oEX_ALU2_COMMIT_TAG;
   logic [4:0]  oEX_ALU2_CMD;
   logic [3:0]  oEX_ALU2_AFE;
   logic        oEX_ALU2_SYS_REG;
   logic        oEX_ALU2_LOGIC;
   logic        oEX_ALU2_SHIFT;
   logic        oEX_ALU2_ADDER;
   logic [31:0] oEX_ALU2_SOURCE0;
   logic [31:0] oEX_ALU2_SOURCE1;
   logic        oEX_ALU2_DESTINATION_SYSREG;
   logic [5:0]  oEX_ALU2_DESTINATION_REGNAME;
   logic        oEX_ALU2_FLAGS_WRITEBACK;
   logic [3:0]  oEX_ALU2_FLAGS_REGNAME;
   logic        iEX_ALU2_LOCK;

   int checks   = 0;
   int failures = 0;

   alu2_reservation_station dut (
      .iCLOCK                       (iCLOCK),
      .inRESET                      (inRESET),
      .iFREE_EX                     (iFREE_EX),
      .iDISP_VALID                  (iDISP_VALID),
      .iDISP_WRITEBACK              (iDISP_WRITEBACK),
      .iDISP_COMMIT_TAG             (iDISP_COMMIT_TAG),
      .iDISP_CMD                    (iDISP_CMD),
      .iDISP_AFE                    (iDISP_AFE),
      .iDISP_SYS_REG                (iDISP_SYS_REG),
      .iDISP_LOGIC                  (iDISP_LOGIC),
      .iDISP_SHIFT                  (iDISP_SHIFT),
      .iDISP_ADDER                  (iDISP_ADDER),
      .iDISP_SRC0_VALID             (iDISP_SRC0_VALID),
      .iDISP_SRC0                   (iDISP_SRC0),
      .iDISP_SRC1_VALID             (iDISP_SRC1_VALID),
      .iDISP_SRC1                   (iDISP_SRC1),
      .iDISP_DESTINATION_SYSREG     (iDISP_DESTINATION_SYSREG),
      .iDISP_DESTINATION_REGNAME    (iDISP_DESTINATION_REGNAME),
      .iDISP_FLAGS_WRITEBACK        (iDISP_FLAGS_WRITEBACK),
      .iDISP_FLAGS_REGNAME          (iDISP_FLAGS_REGNAME),
      .oDISP_LOCK                   (oDISP_LOCK),
      .iWAKE0_VALID                 (iWAKE0_VALID),
      .iWAKE0_TAG                   (iWAKE0_TAG),
      .iWAKE0_DATA                  (iWAKE0_DATA),
      .iWAKE1_VALID                 (iWAKE1_VALID),
      .iWAKE1_TAG                   (iWAKE1_TAG),
      .iWAKE1_DATA                  (iWAKE1_DATA),
      .oEX_ALU2_VALID               (oEX_ALU2_VALID),
      .oEX_ALU2_WRITEBACK           (oEX_ALU2_WRITEBACK),
      .oEX_ALU2_COMMIT_TAG          (oEX_ALU2_COMMIT_TAG),
      .oEX_ALU2_CMD                 (oEX_ALU2_CMD),
      .oEX_ALU2_AFE                 (oEX_ALU2_AFE),
      .oEX_ALU2_SYS_REG             (oEX_ALU2_SYS_REG),
      .oEX_ALU2_LOGIC               (oEX_ALU2_LOGIC),
      .oEX_ALU2_SHIFT               (oEX_ALU2_SHIFT),
      .oEX_ALU2_ADDER               (oEX_ALU2_ADDER),
      .oEX_ALU2_SOURCE0             (oEX_ALU2_SOURCE0),
      .oEX_ALU2_SOURCE1             (oEX_ALU2_SOURCE1),
      .oEX_ALU2_DESTINATION_SYSREG  (oEX_ALU2_DESTINATION_SYSREG),
      .oEX_ALU2_DESTINATION_REGNAME (oEX_ALU2_DESTINATION_REGNAME),
      .oEX_ALU2_FLAGS_WRITEBACK     (oEX_ALU2_FLAGS_WRITEBACK),
      .oEX_ALU2_FLAGS_REGNAME       (oEX_ALU2_FLAGS_REGNAME),
      .iEX_ALU2_LOCK                (iEX_ALU2_LOCK)
   );

   always #5 iCLOCK = ~iCLOCK;

   task automatic step();
      @(posedge iCLOCK);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Side fields are derived from the commit tag so forwarding is visible.
   task automatic disp(input logic [5:0] t, input logic v0,
                       input logic [31:0] s0, input logic v1,
                       input logic [31:0] s1);
      iDISP_VALID               = 1'b1;
      iDISP_WRITEBACK           = 1'b1;
      iDISP_COMMIT_TAG          = t;
      iDISP_CMD                 = t[4:0] ^ 5'h07;
      iDISP_AFE                 = ~t[3:0];
      iDISP_SYS_REG             = t[0];
      iDISP_LOGIC               = t[1];
      iDISP_SHIFT               = t[2];
      iDISP_ADDER               = t[3];
      iDISP_SRC0_VALID          = v0;
      iDISP_SRC0                = s0;
      iDISP_SRC1_VALID          = v1;
      iDISP_SRC1                = s1;
      iDISP_DESTINATION_SYSREG  = t[4];
      iDISP_DESTINATION_REGNAME = t ^ 6'h2A;
      iDISP_FLAGS_WRITEBACK     = t[5];
      iDISP_FLAGS_REGNAME       = t[3:0];
   endtask

   task automatic wake0(input logic v, input logic [5:0] t,
                        input logic [31:0] d);
      iWAKE0_VALID = v;
      iWAKE0_TAG   = t;
      iWAKE0_DATA  = d;
   endtask

   task automatic wake1(input logic v, input logic [5:0] t,
                        input logic [31:0] d);
      iWAKE1_VALID = v;
      iWAKE1_TAG   = t;
      iWAKE1_DATA  = d;
   endtask

   initial begin
      inRESET       = 1'b0;
      iFREE_EX      = 1'b0;
      iEX_ALU2_LOCK = 1'b0;
      disp(6'h00, 1'b1, 32'h0, 1'b1, 32'h0);
      iDISP_VALID   = 1'b0;
      wake0(1'b0, 6'h00, 32'h0);
      wake1(1'b0, 6'h00, 32'h0);
      #1;
      chk("rst_valid", 32'(oEX_ALU2_VALID), 32'h0);
      chk("rst_lock", 32'(oDISP_LOCK), 32'h0);
      chk("rst_src0", oEX_ALU2_SOURCE0, 32'h0);
      chk("rst_tag", 32'(oEX_ALU2_COMMIT_TAG), 32'h0);
      step();
      inRESET = 1'b1;

      // Ready dispatch: accepted at edge 1, issued at edge 2.
      disp(6'h03, 1'b1, 32'h0000_00F0, 1'b1, 32'h0000_000F);
      step();
      iDISP_VALID = 1'b0;
      chk("rdy_e1_valid", 32'(oEX_ALU2_VALID), 32'h0);
      step();
      chk("rdy_valid", 32'(oEX_ALU2_VALID), 32'h1);
      chk("rdy_src0", oEX_ALU2_SOURCE0, 32'h0000_00F0);
      chk("rdy_src1", oEX_ALU2_SOURCE1, 32'h0000_000F);
      chk("rdy_cmd", 32'(oEX_ALU2_CMD), 32'h04);
      chk("rdy_tag", 32'(oEX_ALU2_COMMIT_TAG), 32'h03);
      chk("rdy_afe", 32'(oEX_ALU2_AFE), 32'hC);
      chk("rdy_units", 32'({oEX_ALU2_SYS_REG, oEX_ALU2_LOGIC,
                            oEX_ALU2_SHIFT, oEX_ALU2_ADDER}), 32'hC);
      chk("rdy_wb", 32'(oEX_ALU2_WRITEBACK), 32'h1);
      chk("rdy_dreg", 32'(oEX_ALU2_DESTINATION_REGNAME), 32'h29);
      chk("rdy_dsys", 32'(oEX_ALU2_DESTINATION_SYSREG), 32'h0);
      chk("rdy_flags", 32'({oEX_ALU2_FLAGS_WRITEBACK,
                            oEX_ALU2_FLAGS_REGNAME}), 32'h03);
      step();
      chk("rdy_e3_valid", 32'(oEX_ALU2_VALID), 32'h0);

      // Tag wakeup of a stored operand via WAKE1.
      disp(6'h21, 1'b1, 32'h0000_0011, 1'b0, 32'h0000_0012);
      step();
      iDISP_VALID = 1'b0;
      for (int k = 0; k < 3; k++) begin
         step();
         chk("wk_hold_valid", 32'(oEX_ALU2_VALID), 32'h0);
      end
      wake1(1'b1, 6'h12, 32'hDEAD_BEEF);
      step();
      wake1(1'b0, 6'h00, 32'h0);
      chk("wk_w_valid", 32'(oEX_ALU2_VALID), 32'h0);
      step();
      chk("wk_valid", 32'(oEX_ALU2_VALID), 32'h1);
      chk("wk_tag", 32'(oEX_ALU2_COMMIT_TAG), 32'h21);
      chk("wk_src0", oEX_ALU2_SOURCE0, 32'h0000_0011);
      chk("wk_src1", oEX_ALU2_SOURCE1, 32'hDEAD_BEEF);
      chk("wk_flwb", 32'(oEX_ALU2_FLAGS_WRITEBACK), 32'h1);
      step();
      chk("wk_after", 32'(oEX_ALU2_VALID), 32'h0);

      // Wakeup during dispatch.
      disp(6'h05, 1'b0, 32'h0000_0007, 1'b1, 32'h0000_0005);
      wake0(1'b1, 6'h07, 32'h1234_5678);
      step();
      iDISP_VALID = 1'b0;
      wake0(1'b0, 6'h00, 32'h0);
      chk("sc_e1_valid", 32'(oEX_ALU2_VALID), 32'h0);
      step();
      chk("sc_valid", 32'(oEX_ALU2_VALID), 32'h1);
      chk("sc_src0", oEX_ALU2_SOURCE0, 32'h1234_5678);
      chk("sc_src1", oEX_ALU2_SOURCE1, 32'h0000_0005);

      // Both buses carry the same tag: WAKE0 data wins.
      disp(6'h06, 1'b1, 32'h0000_0001, 1'b0, 32'h0000_0009);
      wake0(1'b1, 6'h09, 32'hAAAA_0000);
      wake1(1'b1, 6'h09, 32'hBBBB_1111);
      step();
      iDISP_VALID = 1'b0;
      wake0(1'b0, 6'h00, 32'h0);
      wake1(1'b0, 6'h00, 32'h0);
      step();
      chk("dbl_valid", 32'(oEX_ALU2_VALID), 32'h1);
      chk("dbl_tag", 32'(oEX_ALU2_COMMIT_TAG), 32'h06);
      chk("dbl_src1", oEX_ALU2_SOURCE1, 32'hAAAA_0000);
      step();
      chk("dbl_after", 32'(oEX_ALU2_VALID), 32'h0);

      // Fill four pending entries; a fifth dispatch is refused.
      for (int k = 0; k < 4; k++) begin
         disp(6'(6'h30 + k), 1'b0, 32'(32'h20 + k), 1'b1, 32'h0);
         step();
         chk(k == 3 ? "fill_lock_on" : "fill_lock_off",
             32'(oDISP_LOCK), k == 3 ? 32'h1 : 32'h0);
      end
      disp(6'h3F, 1'b0, 32'h0000_002F, 1'b1, 32'h0);
      step();
      iDISP_VALID = 1'b0;
      chk("full_lock", 32'(oDISP_LOCK), 32'h1);
      wake0(1'b1, 6'h22, 32'h0000_0222);
      step();
      wake0(1'b0, 6'h00, 32'h0);
      chk("full_w_lock", 32'(oDISP_LOCK), 32'h1);
      chk("full_w_valid", 32'(oEX_ALU2_VALID), 32'h0);
      step();
      chk("e2_valid", 32'(oEX_ALU2_VALID), 32'h1);
      chk("e2_tag", 32'(oEX_ALU2_COMMIT_TAG), 32'h32);
      chk("e2_src0", oEX_ALU2_SOURCE0, 32'h0000_0222);
      chk("e2_lock", 32'(oDISP_LOCK), 32'h0);
      disp(6'h34, 1'b1, 32'h0000_0034, 1'b1, 32'h0000_0043);
      step();
      iDISP_VALID = 1'b0;
      chk("refill_lock", 32'(oDISP_LOCK), 32'h1);
      step();
      chk("refill_tag", 32'(oEX_ALU2_COMMIT_TAG), 32'h34);
      chk("refill_valid", 32'(oEX_ALU2_VALID), 32'h1);
      chk("refill_unlock", 32'(oDISP_LOCK), 32'h0);
      wake0(1'b1, 6'h2F, 32'h0000_0001);
      step();
      wake0(1'b0, 6'h00, 32'h0);
      step();
      chk("fifth_dropped", 32'(oEX_ALU2_VALID), 32'h0);

      // Drain: two wakeups at once, lowest index issues first.
      wake0(1'b1, 6'h20, 32'h0000_00A0);
      wake1(1'b1, 6'h21, 32'h0000_00A1);
      step();
      wake0(1'b0, 6'h00, 32'h0);
      wake1(1'b0, 6'h00, 32'h0);
      step();
      chk("dr0_tag", 32'(oEX_ALU2_COMMIT_TAG), 32'h30);
      chk("dr0_src0", oEX_ALU2_SOURCE0, 32'h0000_00A0);
      step();
      chk("dr1_tag", 32'(oEX_ALU2_COMMIT_TAG), 32'h31);
      chk("dr1_src0", oEX_ALU2_SOURCE0, 32'h0000_00A1);
      wake0(1'b1, 6'h23, 32'h0000_00A3);
      step();
      wake0(1'b0, 6'h00, 32'h0);
      step();
      chk("dr3_tag", 32'(oEX_ALU2_COMMIT_TAG), 32'h33);
      chk("dr3_valid", 32'(oEX_ALU2_VALID), 32'h1);
      step();
      chk("dr_empty", 32'(oEX_ALU2_VALID), 32'h0);

      // Execute lock with two ready entries.
      iEX_ALU2_LOCK = 1'b1;
      disp(6'h10, 1'b1, 32'h0000_0100, 1'b1, 32'h0000_0001);
      step();
      disp(6'h11, 1'b1, 32'h0000_0200, 1'b1, 32'h0000_0002);
      step();
      iDISP_VALID = 1'b0;
      step();
      chk("xl_valid", 32'(oEX_ALU2_VALID), 32'h0);
      chk("xl_tag", 32'(oEX_ALU2_COMMIT_TAG), 32'h33);
      iEX_ALU2_LOCK = 1'b0;
      step();
      chk("xl_rel_valid", 32'(oEX_ALU2_VALID), 32'h1);
      chk("xl_rel_tag", 32'(oEX_ALU2_COMMIT_TAG), 32'h10);
      iEX_ALU2_LOCK = 1'b1;
      step();
      chk("xl_hold_valid", 32'(oEX_ALU2_VALID), 32'h1);
      chk("xl_hold_tag", 32'(oEX_ALU2_COMMIT_TAG), 32'h10);
      iEX_ALU2_LOCK = 1'b0;
      step();
      chk("xl_2nd_tag", 32'(oEX_ALU2_COMMIT_TAG), 32'h11);
      chk("xl_2nd_src0", oEX_ALU2_SOURCE0, 32'h0000_0200);
      step();
      chk("xl_empty", 32'(oEX_ALU2_VALID), 32'h0);

      // Flush against a concurrent dispatch and a ready entry.
      disp(6'h18, 1'b1, 32'h0000_0050, 1'b1, 32'h0);
      step();
      disp(6'h19, 1'b1, 32'h0000_0051, 1'b1, 32'h0);
      iFREE_EX = 1'b1;
      step();
      iFREE_EX    = 1'b0;
      iDISP_VALID = 1'b0;
      chk("fl_valid", 32'(oEX_ALU2_VALID), 32'h0);
      chk("fl_lock", 32'(oDISP_LOCK), 32'h0);
      step();
      chk("fl_e1", 32'(oEX_ALU2_VALID), 32'h0);
      step();
      chk("fl_e2", 32'(oEX_ALU2_VALID), 32'h0);
      for (int k = 0; k < 4; k++) begin
         disp(6'(6'h38 + k), 1'b0, 32'(32'h28 + k), 1'b1, 32'h0);
         step();
      end
      iDISP_VALID = 1'b0;
      chk("fl_full", 32'(oDISP_LOCK), 32'h1);
      iFREE_EX = 1'b1;
      step();
      iFREE_EX = 1'b0;
      chk("fl_unlock", 32'(oDISP_LOCK), 32'h0);

      // Asynchronous reset between edges.
      disp(6'h1A, 1'b1, 32'h0000_0060, 1'b1, 32'h0000_0006);
      step();
      iDISP_VALID = 1'b0;
      step();
      chk("ar_pre_valid", 32'(oEX_ALU2_VALID), 32'h1);
      #2;
      inRESET = 1'b0;
      #1;
      chk("ar_valid", 32'(oEX_ALU2_VALID), 32'h0);
      chk("ar_tag", 32'(oEX_ALU2_COMMIT_TAG), 32'h0);
      chk("ar_src0", oEX_ALU2_SOURCE0, 32'h0);
      chk("ar_lock", 32'(oDISP_LOCK), 32'h0);
      #2;
      inRESET = 1'b1;
      step();
      chk("ar_post", 32'(oEX_ALU2_VALID), 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
